// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common Data Bus arbiter for the Tomasulo datapath. Three functional-unit
//   sources hand in completed results; each source owns a 2-entry FIFO, and
//   one buffered result per cycle is broadcast on the CDB, picked round-robin
//   starting after the most recently granted source.
//
// Handshake (valid/ready, per source i):
//   A transfer happens at a rising Clock edge when Fu_valid[i] and Fu_ready[i]
//   are both 1. Fu_ready[i] depends only on the registered FIFO count, never on
//   Fu_valid or on the pop happening in the same cycle. A source holds its data
//   stable while Fu_valid is high and ready is low.
//
// Ports:
//   Clock            single clock, rising edge
//   Reset            synchronous, active-low
//   Fu_valid[2:0]    source i presents a result
//   Fu_data0..2      result of source i
//   Fu_ready[2:0]    FIFO i can accept this cycle
//   Qi_CDB           registered tag of the broadcast, NO_TAG when idle
//   Qi_CDB_data      registered broadcast data, Vj_Vk_sem_valor when idle
//   Broadcast_count  broadcasts since reset, wraps at 16 bits
module cdb_arbiter #(
  parameter int                 DATA_W          = 16,
  parameter int                 TAG_W           = 4,
  parameter logic [TAG_W-1:0]   TAG_SRC0        = 4'd1,
  parameter logic [TAG_W-1:0]   TAG_SRC1        = 4'd2,
  parameter logic [TAG_W-1:0]   TAG_SRC2        = 4'd3,
  parameter logic [TAG_W-1:0]   NO_TAG          = 4'd0,
  parameter logic [DATA_W-1:0]  Vj_Vk_sem_valor = 16'hFFF0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [2:0]        Fu_valid,
  input  logic [DATA_W-1:0] Fu_data0,
  input  logic [DATA_W-1:0] Fu_data1,
  input  logic [DATA_W-1:0] Fu_data2,
  output logic [2:0]        Fu_ready,
  output logic [TAG_W-1:0]  Qi_CDB,
  output logic [DATA_W-1:0] Qi_CDB_data,
  output logic [15:0]       Broadcast_count
);

  // Per-source FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [3][2];
  logic              head [3];
  logic              tail [3];
  logic [1:0]        cnt [3];

  // Source index of the previous grant; reset to 2 so source 0 goes first
  logic [1:0]        last_grant;

  logic [DATA_W-1:0] fu_data [3];
  logic [2:0]        nonempty;
  logic [2:0]        push_vec;
  logic [2:0]        pop_vec;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic [1:0]        order0, order1, order2;
  logic [TAG_W-1:0]  grant_tag;
  logic [DATA_W-1:0] grant_data;

  assign fu_data[0] = Fu_data0;
  assign fu_data[1] = Fu_data1;
  assign fu_data[2] = Fu_data2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      Fu_ready[i] = (cnt[i] != 2'd2);
      nonempty[i] = (cnt[i] != 2'd0);
    end
  end

  assign push_vec = Fu_valid & Fu_ready;

  // Round-robin search order starting at last_grant+1 (mod 3)
  always_comb begin
    order0 = 2'd0;
    order1 = 2'd1;
    order2 = 2'd2;
    case (last_grant)
      2'd0: begin order0 = 2'd1; order1 = 2'd2; order2 = 2'd0; end
      2'd1: begin order0 = 2'd2; order1 = 2'd0; order2 = 2'd1; end
      default: begin order0 = 2'd0; order1 = 2'd1; order2 = 2'd2; end
    endcase
  end

  // Grant decision uses only pre-edge FIFO state, so a result pushed this
  // cycle can never be broadcast in the same cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    if (nonempty[order0]) begin
      grant_valid = 1'b1;
      grant_idx   = order0;
    end else if (nonempty[order1]) begin
      grant_valid = 1'b1;
      grant_idx   = order1;
    end else if (nonempty[order2]) begin
      grant_valid = 1'b1;
      grant_idx   = order2;
    end
  end

  always_comb begin
    pop_vec    = 3'b000;
    grant_tag  = TAG_SRC2;
    grant_data = mem[2][head[2]];
    case (grant_idx)
      2'd0: begin grant_tag = TAG_SRC0; grant_data = mem[0][head[0]]; end
      2'd1: begin grant_tag = TAG_SRC1; grant_data = mem[1][head[1]]; end
      default: begin grant_tag = TAG_SRC2; grant_data = mem[2][head[2]]; end
    endcase
    if (grant_valid) begin
      pop_vec = 3'b001 << grant_idx;
    end
  end

  // FIFO state
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 3; i++) begin
        head[i] <= 1'b0;
        tail[i] <= 1'b0;
        cnt[i]  <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push_vec[i]) begin
          mem[i][tail[i]] <= fu_data[i];
          tail[i]         <= ~tail[i];
        end
        if (pop_vec[i]) begin
          head[i] <= ~head[i];
        end
        case ({push_vec[i], pop_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Registered CDB outputs
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      last_grant      <= 2'd2;
      Qi_CDB          <= NO_TAG;
      Qi_CDB_data     <= Vj_Vk_sem_valor;
      Broadcast_count <= 16'd0;
    end else if (grant_valid) begin
      last_grant      <= grant_idx;
      Qi_CDB          <= grant_tag;
      Qi_CDB_data     <= grant_data;
      Broadcast_count <= Broadcast_count + 16'd1;
    end else begin
      Qi_CDB          <= NO_TAG;
      Qi_CDB_data     <= Vj_Vk_sem_valor;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the arbiter.
module tb_cdb_arbiter;

  logic        Clock;
  logic        Reset;
  logic [2:0]  Fu_valid;
  logic [15:0] Fu_data0, Fu_data1, Fu_data2;
  logic [2:0]  Fu_ready;
  logic [3:0]  Qi_CDB;
  logic [15:0] Qi_CDB_data;
  logic [15:0] Broadcast_count;

  int n_checks = 0;
  int n_pass   = 0;

  cdb_arbiter dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Fu_valid        (Fu_valid),
    .Fu_data0        (Fu_data0),
    .Fu_data1        (Fu_data1),
    .Fu_data2        (Fu_data2),
    .Fu_ready        (Fu_ready),
    .Qi_CDB          (Qi_CDB),
    .Qi_CDB_data     (Qi_CDB_data),
    .Broadcast_count (Broadcast_count)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  logic [15:0] exp_q [3][$];    // results held per source, oldest first
  int          m_last;
  logic [3:0]  m_tag;
  logic [15:0] m_data;
  logic [15:0] m_cnt;

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (exp_q[i].size() < 2);
    return r;
  endfunction

  function automatic logic [3:0] tag_of(input int s);
    case (s)
      0: return 4'd1;
      1: return 4'd2;
      default: return 4'd3;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Applies inputs, advances the model across the coming edge, and returns
  // #1 after that edge so outputs can be sampled away from it.
  task automatic drive_cycle(input logic rst, input logic [2:0] v,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2);
    logic [15:0] d [3];
    logic [2:0]  rdy;
    int          g;
    Reset = rst; Fu_valid = v;
    Fu_data0 = d0; Fu_data1 = d1; Fu_data2 = d2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    rdy = m_ready();
    if (!rst) begin
      for (int i = 0; i < 3; i++) exp_q[i].delete();
      m_last = 2; m_tag = 4'd0; m_data = 16'hFFF0; m_cnt = 16'd0;
    end else begin
      g = -1;
      for (int k = 0; k < 3; k++) begin
        int s;
        s = (m_last + 1 + k) % 3;
        if (g < 0 && exp_q[s].size() > 0) g = s;
      end
      if (g >= 0) begin
        m_tag  = tag_of(g);
        m_data = exp_q[g].pop_front();
        m_last = g;
        m_cnt  = m_cnt + 16'd1;
      end else begin
        m_tag  = 4'd0;
        m_data = 16'hFFF0;
      end
      for (int i = 0; i < 3; i++)
        if (v[i] && rdy[i]) exp_q[i].push_back(d[i]);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_cycle(1'b0, 3'b111, 16'h1111, 16'h2222, 16'h3333);
    drive_cycle(1'b0, 3'b111, 16'h1111, 16'h2222, 16'h3333);
    n_checks++; if (Qi_CDB !== 4'd0) $display("FAIL reset_tag: got %0d want 0", Qi_CDB); else n_pass++;
    n_checks++; if (Qi_CDB_data !== 16'hFFF0) $display("FAIL reset_data: got %h want fff0", Qi_CDB_data); else n_pass++;
    n_checks++; if (Fu_ready !== 3'b111) $display("FAIL reset_ready: got %b want 111", Fu_ready); else n_pass++;
    n_checks++; if (Broadcast_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", Broadcast_count); else n_pass++;
    idle_cycle();
    idle_cycle();
    n_checks++; if (Qi_CDB !== 4'd0) $display("FAIL reset_nothing_buffered: got tag %0d want 0", Qi_CDB); else n_pass++;
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 3'b010, 16'h0, 16'h0005, 16'h0);   // edge k
    n_checks++; if (Qi_CDB !== 4'd0) $display("FAIL single_no_passthru: got tag %0d want 0", Qi_CDB); else n_pass++;
    idle_cycle();                                         // edge k+1
    n_checks++; if (Qi_CDB !== 4'd2) $display("FAIL single_tag: got %0d want 2", Qi_CDB); else n_pass++;
    n_checks++; if (Qi_CDB_data !== 16'h0005) $display("FAIL single_data: got %h want 0005", Qi_CDB_data); else n_pass++;
    n_checks++; if (Broadcast_count !== 16'd1) $display("FAIL single_count: got %0d want 1", Broadcast_count); else n_pass++;
    idle_cycle();                                         // edge k+2
    n_checks++; if (Qi_CDB !== 4'd0 || Qi_CDB_data !== 16'hFFF0)
      $display("FAIL single_idle: got tag %0d data %h want 0 fff0", Qi_CDB, Qi_CDB_data); else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0]  et [3];
    logic [15:0] ed [3];
    et[0] = 4'd1; et[1] = 4'd2; et[2] = 4'd3;
    ed[0] = 16'h000A; ed[1] = 16'h000B; ed[2] = 16'h000C;
    drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
    drive_cycle(1'b1, 3'b111, 16'h000A, 16'h000B, 16'h000C);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      n_checks++; if (Qi_CDB !== et[i] || Qi_CDB_data !== ed[i])
        $display("FAIL contention_%0d: got tag %0d data %h want %0d %h", i, Qi_CDB, Qi_CDB_data, et[i], ed[i]);
      else n_pass++;
    end
    idle_cycle();
    n_checks++; if (Qi_CDB !== 4'd0) $display("FAIL contention_drained: got tag %0d want 0", Qi_CDB); else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic saw_r2_low;
    logic [2:0] v;
    saw_r2_low = 1'b0;
    drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
    for (int c = 0; c < 16; c++) begin
      v = 3'b000;
      if (c < 8) v[1:0] = 2'b11;
      if (c < 4) v[2] = 1'b1;
      n_checks++; if (Fu_ready !== m_ready())
        $display("FAIL bp_ready cyc %0d: got %b want %b", c, Fu_ready, m_ready()); else n_pass++;
      if (Fu_ready[2] === 1'b0) saw_r2_low = 1'b1;
      drive_cycle(1'b1, v, 16'($urandom), 16'($urandom), 16'($urandom));
      n_checks++; if (Qi_CDB !== m_tag || Qi_CDB_data !== m_data)
        $display("FAIL bp_cdb cyc %0d: got tag %0d data %h want %0d %h", c, Qi_CDB, Qi_CDB_data, m_tag, m_data);
      else n_pass++;
    end
    n_checks++; if (saw_r2_low !== 1'b1) $display("FAIL bp_ready2_drop: got %b want 1", saw_r2_low); else n_pass++;
    n_checks++; if (Qi_CDB !== 4'd0 || Broadcast_count !== m_cnt)
      $display("FAIL bp_drained: got tag %0d count %0d want 0 %0d", Qi_CDB, Broadcast_count, m_cnt); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      n_checks++; if (Fu_ready !== m_ready())
        $display("FAIL rand_ready cyc %0d: got %b want %b", c, Fu_ready, m_ready()); else n_pass++;
      drive_cycle(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom));
      n_checks++; if (Qi_CDB !== m_tag || Qi_CDB_data !== m_data || Broadcast_count !== m_cnt)
        $display("FAIL rand_cdb cyc %0d: got tag %0d data %h cnt %0d want %0d %h %0d",
                 c, Qi_CDB, Qi_CDB_data, Broadcast_count, m_tag, m_data, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) drive_cycle(1'b1, 3'b111, 16'($urandom), 16'($urandom), 16'($urandom));
    drive_cycle(1'b0, 3'b111, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    n_checks++; if (Qi_CDB !== 4'd0 || Qi_CDB_data !== 16'hFFF0 || Broadcast_count !== 16'd0)
      $display("FAIL midreset_idle: got tag %0d data %h cnt %0d want 0 fff0 0", Qi_CDB, Qi_CDB_data, Broadcast_count);
    else n_pass++;
    n_checks++; if (Fu_ready !== 3'b111) $display("FAIL midreset_ready: got %b want 111", Fu_ready); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      idle_cycle();
      n_checks++; if (Qi_CDB !== 4'd0) $display("FAIL midreset_stale cyc %0d: got tag %0d want 0", c, Qi_CDB); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    drive_cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
    // first push produces no broadcast; the next 65536 cycles broadcast once each
    for (int c = 0; c < 65537; c++) drive_cycle(1'b1, 3'b001, 16'($urandom), 16'h0, 16'h0);
    n_checks++; if (Broadcast_count !== 16'd0) $display("FAIL wrap_count: got %0d want 0", Broadcast_count); else n_pass++;
    n_checks++; if (Qi_CDB !== m_tag || Qi_CDB_data !== m_data)
      $display("FAIL wrap_last: got tag %0d data %h want %0d %h", Qi_CDB, Qi_CDB_data, m_tag, m_data); else n_pass++;
    drive_cycle(1'b1, 3'b111, 16'h0111, 16'h0222, 16'h0333);
    for (int c = 0; c < 5; c++) begin
      idle_cycle();
      n_checks++; if (Qi_CDB !== m_tag || Qi_CDB_data !== m_data || Broadcast_count !== m_cnt)
        $display("FAIL wrap_arb cyc %0d: got tag %0d data %h cnt %0d want %0d %h %0d",
                 c, Qi_CDB, Qi_CDB_data, Broadcast_count, m_tag, m_data, m_cnt);
      else n_pass++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    Reset = 1'b0; Fu_valid = 3'b000;
    Fu_data0 = 16'h0; Fu_data1 = 16'h0; Fu_data2 = 16'h0;
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
